// File: rtl/spike_log_pkg.sv
// Shared encodings and sizes for the spike raster logger.
package spike_log_pkg;
  localparam int WORD_W      = 16;
  localparam int FRAME_WORDS = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STAMP  = 2'd1,
    RASTER = 2'd2
  } state_t;
endpackage

// File: rtl/fifo_fwft.sv
// First-word-fall-through FIFO: the head word is visible on rd_data while
// the FIFO is non-empty, and rd_data reads as zero when empty.
module fifo_fwft #(
  parameter int WIDTH      = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  rd_en,
  output logic [WIDTH-1:0]      rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(1) << DEPTH_LOG2;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  w_push;
  logic                  w_pop;

  assign empty   = (r_count == '0);
  assign full    = (r_count == DEPTH_CNT);
  assign count   = r_count;
  assign w_push  = wr_en & ~full;
  assign w_pop   = rd_en & ~empty;
  assign rd_data = empty ? '0 : r_mem[r_rd_ptr];

  // Storage array; contents are don't-care until pointed at, so no reset.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  // Pointers wrap naturally at the power-of-two depth; push+pop keeps count.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/spike_raster_logger.sv
// Collects spike pulses between simulation ticks and queues one two-word
// frame (stamp, raster) per tick into a FWFT FIFO for the pipe-out reader.
module spike_raster_logger
  import spike_log_pkg::*;
#(
  parameter int NCH        = 16,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  tick,
  input  logic [NCH-1:0]        spikes,
  input  logic                  rd_en,
  output logic [WORD_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow,
  output logic [15:0]           frame_cnt
);
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT  = (DEPTH_LOG2+1)'(1) << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] NEED_WORDS = (DEPTH_LOG2+1)'(FRAME_WORDS);

  state_t              r_state;
  logic                r_tick_d;
  logic [NCH-1:0]      r_acc;
  logic [NCH-1:0]      r_snapshot;
  logic [15:0]         r_frame_cnt;
  logic                r_overflow;

  logic                w_tick_rise;
  logic                w_room;
  logic                w_capture;
  logic                w_wr_en;
  logic [WORD_W-1:0]   w_wr_data;
  logic [WORD_W-1:0]   w_raster;
  logic [DEPTH_LOG2:0] w_count;
  logic                w_empty;
  logic                w_full;

  assign w_tick_rise = tick & ~r_tick_d;
  assign w_room      = (DEPTH_CNT - w_count) >= NEED_WORDS;
  assign w_capture   = (r_state == IDLE) & w_tick_rise & enable & w_room;
  assign w_wr_en     = (r_state == STAMP) | (r_state == RASTER);
  assign w_wr_data   = (r_state == STAMP) ? r_frame_cnt : w_raster;

  // Raster word: unused upper channel bits read as zero.
  always_comb begin
    w_raster = '0;
    w_raster[NCH-1:0] = r_snapshot;
  end

  // Tick edge detector.
  always_ff @(posedge clk) begin
    if (reset) r_tick_d <= 1'b0;
    else       r_tick_d <= tick;
  end

  // Accumulate pulses; a capture folds in this cycle's pulses so nothing
  // straddling the edge is lost or counted twice.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc      <= '0;
      r_snapshot <= '0;
    end else if (w_capture) begin
      r_snapshot <= r_acc | spikes;
      r_acc      <= '0;
    end else begin
      r_acc      <= r_acc | spikes;
    end
  end

  // Frame sequencer: stamp then raster; dropped or missed ticks flag overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_frame_cnt <= '0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_tick_rise && enable) begin
            if (w_room) begin
              r_state <= STAMP;
            end else begin
              r_overflow  <= 1'b1;
              r_frame_cnt <= r_frame_cnt + 16'd1;
            end
          end
        end
        STAMP: begin
          if (w_tick_rise && enable) r_overflow <= 1'b1;
          r_state <= RASTER;
        end
        RASTER: begin
          if (w_tick_rise && enable) r_overflow <= 1'b1;
          r_frame_cnt <= r_frame_cnt + 16'd1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  fifo_fwft #(
    .WIDTH      (WORD_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (w_wr_en),
    .wr_data (w_wr_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (w_empty),
    .full    (w_full),
    .count   (w_count)
  );

  assign rd_valid  = ~w_empty;
  assign count     = w_count;
  assign overflow  = r_overflow;
  assign frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_spike_raster_logger.sv
// Directed bench for spike_raster_logger with an 8-word FIFO.
module tb_spike_raster_logger;
  localparam int NCH = 16;
  localparam int DL2 = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            enable;
  logic            tick;
  logic [NCH-1:0]  spikes;
  logic            rd_en;
  logic [15:0]     rd_data;
  logic            rd_valid;
  logic [DL2:0]    count;
  logic            overflow;
  logic [15:0]     frame_cnt;

  int total = 0;
  int bad   = 0;

  spike_raster_logger #(.NCH(NCH), .DEPTH_LOG2(DL2)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .tick      (tick),
    .spikes    (spikes),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .count     (count),
    .overflow  (overflow),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; tick = 1'b0; spikes = '0; rd_en = 1'b0; enable = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1; cyc();
    tick = 1'b0; cyc(); cyc(); cyc();
  endtask

  task automatic pulse(input logic [NCH-1:0] s);
    spikes = s; cyc(); spikes = '0;
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] exp);
    chk(tag, {16'd0, rd_data}, {16'd0, exp});
    rd_en = 1'b1; cyc(); rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle
    do_reset();
    repeat (100) cyc();
    chk("idle_valid", 32'(rd_valid), 32'd0);
    chk("idle_count", 32'(count), 32'd0);
    chk("idle_data", 32'(rd_data), 32'd0);
    chk("idle_ovf", 32'(overflow), 32'd0);
    chk("idle_fcnt", 32'(frame_cnt), 32'd0);

    // Disabled tick is ignored
    enable = 1'b0;
    do_tick();
    chk("dis_count", 32'(count), 32'd0);
    chk("dis_fcnt", 32'(frame_cnt), 32'd0);
    chk("dis_ovf", 32'(overflow), 32'd0);
    enable = 1'b1;

    // Single frame
    pulse(16'h0005);
    repeat (9) cyc();
    tick = 1'b1; cyc();
    chk("sf_valid_n1", 32'(rd_valid), 32'd0);
    cyc();
    chk("sf_valid_n2", 32'(rd_valid), 32'd1);
    chk("sf_stamp", 32'(rd_data), 32'h0000);
    chk("sf_count1", 32'(count), 32'd1);
    cyc();
    chk("sf_count2", 32'(count), 32'd2);
    chk("sf_fcnt", 32'(frame_cnt), 32'd1);
    tick = 1'b0;
    pop_chk("sf_rd0", 16'h0000);
    pop_chk("sf_rd1", 16'h0005);
    chk("sf_empty_valid", 32'(rd_valid), 32'd0);
    chk("sf_empty_data", 32'(rd_data), 32'd0);

    // Empty read is ignored
    rd_en = 1'b1; cyc(); rd_en = 1'b0;
    chk("under_count", 32'(count), 32'd0);

    // Capture-edge spikes
    tick = 1'b1; spikes = 16'h0008; cyc();
    spikes = 16'h0010; cyc();
    spikes = '0; cyc();
    tick = 1'b0; cyc();
    tick = 1'b1; cyc(); cyc(); cyc();
    tick = 1'b0; cyc();
    chk("ce_count", 32'(count), 32'd4);
    pop_chk("ce_s1", 16'h0001);
    pop_chk("ce_r1", 16'h0008);
    pop_chk("ce_s2", 16'h0002);
    pop_chk("ce_r2", 16'h0010);

    // Full / drop
    do_reset();
    repeat (4) do_tick();
    chk("fd_count8", 32'(count), 32'd8);
    chk("fd_fcnt4", 32'(frame_cnt), 32'd4);
    chk("fd_ovf0", 32'(overflow), 32'd0);
    pulse(16'h0001);
    do_tick();
    chk("fd_drop_count", 32'(count), 32'd8);
    chk("fd_drop_ovf", 32'(overflow), 32'd1);
    chk("fd_drop_fcnt", 32'(frame_cnt), 32'd5);
    pop_chk("fd_head", 16'h0000);
    chk("fd_count7", 32'(count), 32'd7);
    do_tick();
    chk("fd_drop2_count", 32'(count), 32'd7);
    chk("fd_drop2_fcnt", 32'(frame_cnt), 32'd6);
    rd_en = 1'b1; cyc(); cyc(); rd_en = 1'b0;
    chk("fd_count5", 32'(count), 32'd5);
    do_tick();
    chk("fd_wr_count", 32'(count), 32'd7);
    chk("fd_wr_fcnt", 32'(frame_cnt), 32'd7);
    pop_chk("fd_d0", 16'h0000);
    pop_chk("fd_d1", 16'h0002);
    pop_chk("fd_d2", 16'h0000);
    pop_chk("fd_d3", 16'h0003);
    pop_chk("fd_d4", 16'h0000);
    pop_chk("fd_d5", 16'h0006);
    pop_chk("fd_d6", 16'h0001);
    chk("fd_empty", 32'(rd_valid), 32'd0);

    // Concurrent read and write
    do_reset();
    pulse(16'h0011); do_tick();
    pulse(16'h0022); do_tick();
    chk("cc_count_pre", 32'(count), 32'd4);
    pulse(16'h0044);
    tick = 1'b1; cyc();
    rd_en = 1'b1; cyc();
    chk("cc_count_stamp", 32'(count), 32'd4);
    cyc();
    rd_en = 1'b0; tick = 1'b0;
    chk("cc_count_raster", 32'(count), 32'd4);
    cyc();
    pop_chk("cc_d0", 16'h0001);
    pop_chk("cc_d1", 16'h0022);
    pop_chk("cc_d2", 16'h0002);
    pop_chk("cc_d3", 16'h0044);

    // Fast tick: every second rise lands mid-frame
    do_reset();
    tick = 1'b1; cyc();
    tick = 1'b0; cyc();
    chk("ft_ovf_pre", 32'(overflow), 32'd0);
    tick = 1'b1; cyc();
    chk("ft_ovf_set", 32'(overflow), 32'd1);
    tick = 1'b0; cyc();
    tick = 1'b1; cyc();
    tick = 1'b0; cyc();
    tick = 1'b1; cyc();
    tick = 1'b0; cyc(); cyc();
    chk("ft_fcnt", 32'(frame_cnt), 32'd2);
    chk("ft_count", 32'(count), 32'd4);
    chk("ft_ovf_hold", 32'(overflow), 32'd1);

    // Frame counter wrap
    do_reset();
    @(negedge clk);
    force dut.r_frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_frame_cnt;
    cyc();
    chk("wr_fcnt_pre", 32'(frame_cnt), 32'h0000FFFF);
    do_tick();
    chk("wr_stamp", 32'(rd_data), 32'h0000FFFF);
    chk("wr_fcnt", 32'(frame_cnt), 32'd0);
    chk("wr_ovf", 32'(overflow), 32'd0);
    chk("wr_count", 32'(count), 32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spike_raster_logger.md
Name: spike_raster_logger

Overview:
- Downstream consumer of the motoneuron pools' spike outputs.
- Accumulates per-channel spike pulses between simulation ticks and packs each tick into a two-word frame: a 16-bit frame stamp followed by a 16-bit raster.
- Buffers frames in an on-chip FIFO and drives the 16-bit block-throttled pipe-out data (rawspikes) with a first-word-fall-through read handshake.

Parameters:
- NCH, 16: number of spike channels (1..16); raster bits above NCH-1 are written as 0.
- DEPTH_LOG2, 10: FIFO depth = 2**DEPTH_LOG2 16-bit words.

Ports:
- clk  input  1  single clock for all logic (clk1 domain).
- reset  input  1  synchronous, active-high; clears everything.
- enable  input  1  when 0, ticks are ignored and accumulation continues; FIFO reads still serviced.
- tick  input  1  simulation step (sim_clk level); the frame trigger is its rising edge, sampled on clk.
- spikes  input  NCH  single-cycle spike pulses, one bit per motoneuron channel.
- rd_en  input  1  pop request from the pipe-out read strobe.
- rd_data  output  16  head-of-FIFO word, valid while rd_valid=1; 16'h0000 when empty.
- rd_valid  output  1  FIFO non-empty.
- count  output  DEPTH_LOG2+1  words currently stored.
- overflow  output  1  sticky; set on any dropped frame or missed tick.
- frame_cnt  output  16  current frame stamp.

Behaviour:
- Reset: state=IDLE; accumulator=0; tick_d=0; FIFO empty; rd_valid=0; rd_data=0; count=0; overflow=0; frame_cnt=0. A reset mid-frame aborts the frame, and any half-written word pair is discarded with the FIFO.
- Edge detect: tick_d <= tick; tick_rise = tick & ~tick_d.
- Accumulator: acc <= acc | spikes every cycle.
  - On frame capture: snapshot <= acc | spikes, acc <= 0.
  - No spike is lost or double-counted across a capture edge.
- FSM states: IDLE, STAMP, RASTER.
  - IDLE: if tick_rise & enable and free slots (2**DEPTH_LOG2 - count) >= 2, capture the snapshot and go to STAMP.
  - IDLE, insufficient space: if tick_rise & enable and free < 2, drop the whole frame. No partial frame is written. Set overflow, increment frame_cnt, do not clear acc, stay in IDLE.
  - STAMP: write frame_cnt, go to RASTER.
  - RASTER: write the snapshot (zero-extended to 16), increment frame_cnt, go to IDLE.
- frame_cnt wraps 16'hFFFF -> 16'h0000 without flagging.
- Tick during STAMP or RASTER: ignored; overflow set; spikes stay in acc and appear in the next frame.
- Latency: with tick_rise in cycle N, the stamp is written at the end of N+1 and the raster at the end of N+2.
  - On an empty FIFO, rd_valid=1 and rd_data=stamp from cycle N+2.
  - Minimum tick period is 3 clk.
- FIFO is first-word-fall-through.
  - rd_en with rd_valid=1 pops; rd_data shows the next word the following cycle.
  - rd_en on empty is ignored, with no underflow flag.
  - Simultaneous write and pop: both occur and count is unchanged.
  - Pointers wrap modulo depth. The full condition is count = 2**DEPTH_LOG2; the FSM guarantees no write when full.
- overflow clears only on reset.

Decomposition:
- Shared package spike_log_pkg holds:
  - state encoding: IDLE=2'd0, STAMP=2'd1, RASTER=2'd2;
  - WORD_W=16 and FRAME_WORDS=2.
- Sub-module fifo_fwft (parameters WIDTH, DEPTH_LOG2).
  - Ports: clk, reset, wr_en, wr_data, rd_en, rd_data, empty, full, count.
  - The FSM, accumulator and edge detect stay in the top module.

Test Plan:
- Reset then idle: no tick, spikes=0 for 100 cycles -> rd_valid=0, count=0, rd_data=16'h0000, overflow=0.
- Single frame: spikes=16'h0005 pulsed once, tick rising 10 cycles later -> FIFO holds 16'h0000 then 16'h0005; count=2; frame_cnt=1; rd_valid high 2 cycles after tick_rise.
- Capture-edge spike: spike bit 3 pulses in the same cycle as tick_rise, bit 4 pulses the next cycle -> frame 0 raster=16'h0008; frame 1 raster=16'h0010.
- Full/drop: DEPTH_LOG2=3, no reads, 5 ticks -> first 4 frames stored (count=8); 5th dropped; overflow=1; frame_cnt=5; one read then tick -> still dropped (free=1); two more reads then tick -> frame stamp 16'h0006 written.
- Concurrent read/write: at count=4, rd_en held high during the RASTER write cycle -> count stays 4; read order preserved (stamp, raster, ...).
- Fast tick and wrap: tick period 2 clk -> every second rise ignored and overflow=1. Force frame_cnt to 16'hFFFF, then one frame -> stamp 16'hFFFF, frame_cnt=16'h0000.
